// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: AHB-lite control block for the CNN accelerator.
// Holds frame geometry and a table of per-layer descriptors. A small sequencer
// launches the programmed layers back-to-back into the frame FSM and raises a
// sticky done flag (with optional interrupt) once the last layer has finished.
module cnn_layer_sequencer #(
    parameter int unsigned W_ADDR         = 32,
    parameter int unsigned W_DATA         = 32,
    parameter int unsigned N_SLOTS        = 8,
    parameter int unsigned WIDTH          = 128,
    parameter int unsigned HEIGHT         = 128,
    parameter int unsigned START_UP_DELAY = 200,
    parameter int unsigned HSYNC_DELAY    = 160,
    parameter int unsigned W_SIZE         = 12,
    parameter int unsigned W_DELAY        = 12
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                sl_HSEL,
    input  logic                sl_HREADY,
    input  logic                sl_HWRITE,
    input  logic [1:0]          sl_HTRANS,
    input  logic [2:0]          sl_HBURST,
    input  logic [2:0]          sl_HSIZE,
    input  logic [W_ADDR-1:0]   sl_HADDR,
    input  logic [W_DATA-1:0]   sl_HWDATA,
    output logic                out_sl_HREADY,
    output logic [1:0]          out_sl_HRESP,
    output logic [W_DATA-1:0]   out_sl_HRDATA,
    input  logic                i_end_frame,
    output logic                o_layer_start,
    output logic [W_SIZE-1:0]   o_width,
    output logic [W_SIZE-1:0]   o_height,
    output logic [2*W_SIZE:0]   o_frame_size,
    output logic [W_DELAY-1:0]  o_start_up_delay,
    output logic [W_DELAY-1:0]  o_hsync_delay,
    output logic                o_is_first_layer,
    output logic                o_is_last_layer,
    output logic                o_is_conv3x3,
    output logic                o_act_type,
    output logic [3:0]          o_layer_index,
    output logic [4:0]          o_bias_shift,
    output logic [2:0]          o_act_shift,
    output logic [19:0]         o_base_addr_weight,
    output logic [11:0]         o_base_addr_param,
    output logic                o_busy,
    output logic                o_irq
);

    localparam int unsigned W_FRAME_SIZE = 2 * W_SIZE + 1;
    localparam int unsigned W_REGS       = $clog2(8 + 2 * N_SLOTS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    // Bus pipeline
    logic                    accept;
    logic [W_REGS-1:0]       addr_q;
    logic                    wr_q;

    // Programmable registers
    logic [W_FRAME_SIZE-1:0] frame_q, frame_d;
    logic [W_SIZE-1:0]       width_q, width_d;
    logic [W_SIZE-1:0]       height_q, height_d;
    logic [W_DELAY-1:0]      su_delay_q, su_delay_d;
    logic [W_DELAY-1:0]      hs_delay_q, hs_delay_d;
    logic [4:0]              num_q, num_d;
    logic                    irq_en_q, irq_en_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [15:0]             cfg_q [N_SLOTS];
    logic [15:0]             cfg_d [N_SLOTS];
    logic [31:0]             base_q [N_SLOTS];
    logic [31:0]             base_d [N_SLOTS];

    // Sequencer
    logic [1:0]              state_q, state_d;
    logic [3:0]              slot_q, slot_d;
    logic                    busy;
    logic                    load_en;
    logic [3:0]              load_slot;
    logic [15:0]             sel_cfg;
    logic [31:0]             sel_base;

    // Registered layer outputs
    logic [W_FRAME_SIZE-1:0] out_frame_q;
    logic [W_SIZE-1:0]       out_width_q, out_height_q;
    logic [W_DELAY-1:0]      out_su_q, out_hs_q;
    logic [15:0]             out_cfg_q;
    logic [31:0]             out_base_q;
    logic                    irq_q;

    // Write-side decode helpers
    logic                    ctrl_wr, start_bit, abort_bit, abort, done_set, err_set;
    logic                    done_clr, err_clr;
    logic [4:0]              new_num;

    logic                    unused_ok;
    assign unused_ok = ^{sl_HBURST, sl_HSIZE, sl_HTRANS[0],
                         sl_HADDR[W_ADDR-1:W_REGS+2], sl_HADDR[1:0]};

    assign accept = sl_HSEL & sl_HREADY & sl_HTRANS[1];
    assign busy   = (state_q != ST_IDLE);

    // Capture the address phase; the data phase follows one cycle later
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            wr_q <= accept & sl_HWRITE;
            if (accept) begin
                addr_q <= sl_HADDR[W_REGS+1:2];
            end
        end
    end

    // Register writes, status flags and the sequencer next state
    always_comb begin
        frame_d    = frame_q;
        width_d    = width_q;
        height_d   = height_q;
        su_delay_d = su_delay_q;
        hs_delay_d = hs_delay_q;
        num_d      = num_q;
        irq_en_d   = irq_en_q;
        cfg_d      = cfg_q;
        base_d     = base_q;
        state_d    = state_q;
        slot_d     = slot_q;
        load_en    = 1'b0;
        load_slot  = slot_q;
        done_set   = 1'b0;
        err_set    = 1'b0;
        done_clr   = 1'b0;
        err_clr    = 1'b0;

        ctrl_wr    = wr_q && (addr_q == W_REGS'(3));
        start_bit  = sl_HWDATA[0];
        abort_bit  = sl_HWDATA[1];
        new_num    = sl_HWDATA[8:4];
        abort      = ctrl_wr && abort_bit && busy;

        if (wr_q && addr_q == W_REGS'(0)) begin
            if (busy) err_set = 1'b1;
            else      frame_d = sl_HWDATA[W_FRAME_SIZE-1:0];
        end
        if (wr_q && addr_q == W_REGS'(1)) begin
            if (busy) begin
                err_set = 1'b1;
            end else begin
                width_d  = sl_HWDATA[W_SIZE-1:0];
                height_d = sl_HWDATA[16+W_SIZE-1:16];
            end
        end
        if (wr_q && addr_q == W_REGS'(2)) begin
            if (busy) begin
                err_set = 1'b1;
            end else begin
                su_delay_d = sl_HWDATA[W_DELAY-1:0];
                hs_delay_d = sl_HWDATA[2*W_DELAY-1:W_DELAY];
            end
        end
        // While busy a pure abort is the only harmless CTRL write
        if (ctrl_wr) begin
            if (busy) begin
                if (start_bit || !abort_bit) err_set = 1'b1;
            end else begin
                num_d = new_num;
            end
        end
        if (wr_q && addr_q == W_REGS'(4)) begin
            done_clr = sl_HWDATA[1];
            err_clr  = sl_HWDATA[2];
        end
        if (wr_q && addr_q == W_REGS'(5)) begin
            irq_en_d = sl_HWDATA[0];
        end
        for (int k = 0; k < int'(N_SLOTS); k++) begin
            if (wr_q && addr_q == W_REGS'(8 + 2 * k)) begin
                if (busy) err_set = 1'b1;
                else      cfg_d[k] = sl_HWDATA[15:0];
            end
            if (wr_q && addr_q == W_REGS'(9 + 2 * k)) begin
                if (busy) err_set = 1'b1;
                else      base_d[k] = sl_HWDATA[31:0];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr && start_bit) begin
                    // The layer count written with the start bit is the one used
                    if (new_num != 5'd0 && 32'(new_num) <= N_SLOTS) begin
                        slot_d    = 4'd0;
                        state_d   = ST_LAUNCH;
                        load_en   = 1'b1;
                        load_slot = 4'd0;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN: begin
                if (i_end_frame) begin
                    if ({1'b0, slot_q} == num_q - 5'd1) begin
                        state_d  = ST_IDLE;
                        done_set = 1'b1;
                    end else begin
                        slot_d  = slot_q + 4'd1;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                state_d   = ST_LAUNCH;
                load_en   = 1'b1;
                load_slot = slot_q;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides whatever the sequencer decided this cycle
        if (abort) begin
            state_d  = ST_IDLE;
            slot_d   = slot_q;
            load_en  = 1'b0;
            done_set = 1'b0;
        end

        // Setting wins over a simultaneous write-1-to-clear
        done_d = done_set | (done_q & ~done_clr);
        err_d  = err_set | (err_q & ~err_clr);
    end

    // Programmable register and sequencer state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            frame_q    <= W_FRAME_SIZE'(WIDTH * HEIGHT);
            width_q    <= W_SIZE'(WIDTH);
            height_q   <= W_SIZE'(HEIGHT);
            su_delay_q <= W_DELAY'(START_UP_DELAY);
            hs_delay_q <= W_DELAY'(HSYNC_DELAY);
            num_q      <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            irq_q      <= 1'b0;
            for (int k = 0; k < int'(N_SLOTS); k++) begin
                cfg_q[k]  <= '0;
                base_q[k] <= '0;
            end
        end else begin
            frame_q    <= frame_d;
            width_q    <= width_d;
            height_q   <= height_d;
            su_delay_q <= su_delay_d;
            hs_delay_q <= hs_delay_d;
            num_q      <= num_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            state_q    <= state_d;
            slot_q     <= slot_d;
            irq_q      <= irq_en_q & done_q;
            cfg_q      <= cfg_d;
            base_q     <= base_d;
        end
    end

    // Pick the descriptor for the slot about to launch
    always_comb begin
        sel_cfg  = '0;
        sel_base = '0;
        for (int k = 0; k < int'(N_SLOTS); k++) begin
            if (load_slot == 4'(k)) begin
                sel_cfg  = cfg_q[k];
                sel_base = base_q[k];
            end
        end
    end

    // Layer outputs are loaded on entry to LAUNCH and held until the next load
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            out_frame_q  <= W_FRAME_SIZE'(WIDTH * HEIGHT);
            out_width_q  <= W_SIZE'(WIDTH);
            out_height_q <= W_SIZE'(HEIGHT);
            out_su_q     <= W_DELAY'(START_UP_DELAY);
            out_hs_q     <= W_DELAY'(HSYNC_DELAY);
            out_cfg_q    <= '0;
            out_base_q   <= '0;
        end else if (load_en) begin
            out_frame_q  <= frame_q;
            out_width_q  <= width_q;
            out_height_q <= height_q;
            out_su_q     <= su_delay_q;
            out_hs_q     <= hs_delay_q;
            out_cfg_q    <= sel_cfg;
            out_base_q   <= sel_base;
        end
    end

    // Read mux, driven from the registered word index during the data phase
    always_comb begin
        out_sl_HRDATA = '0;
        case (addr_q)
            W_REGS'(0): out_sl_HRDATA[W_FRAME_SIZE-1:0] = frame_q;
            W_REGS'(1): begin
                out_sl_HRDATA[W_SIZE-1:0]       = width_q;
                out_sl_HRDATA[16+W_SIZE-1:16]   = height_q;
            end
            W_REGS'(2): begin
                out_sl_HRDATA[W_DELAY-1:0]         = su_delay_q;
                out_sl_HRDATA[2*W_DELAY-1:W_DELAY] = hs_delay_q;
            end
            W_REGS'(3): out_sl_HRDATA[8:4] = num_q;
            W_REGS'(4): begin
                out_sl_HRDATA[0]    = busy;
                out_sl_HRDATA[1]    = done_q;
                out_sl_HRDATA[2]    = err_q;
                out_sl_HRDATA[11:8] = slot_q;
            end
            W_REGS'(5): out_sl_HRDATA[0] = irq_en_q;
            default: begin
                for (int k = 0; k < int'(N_SLOTS); k++) begin
                    if (addr_q == W_REGS'(8 + 2 * k)) out_sl_HRDATA[15:0] = cfg_q[k];
                    if (addr_q == W_REGS'(9 + 2 * k)) out_sl_HRDATA[31:0] = base_q[k];
                end
            end
        endcase
    end

    assign out_sl_HREADY      = 1'b1;
    assign out_sl_HRESP       = 2'b00;
    assign o_layer_start      = (state_q == ST_LAUNCH);
    assign o_busy             = busy;
    assign o_irq              = irq_q;
    assign o_width            = out_width_q;
    assign o_height           = out_height_q;
    assign o_frame_size       = out_frame_q;
    assign o_start_up_delay   = out_su_q;
    assign o_hsync_delay      = out_hs_q;
    assign o_is_first_layer   = out_cfg_q[0];
    assign o_is_last_layer    = out_cfg_q[1];
    assign o_is_conv3x3       = out_cfg_q[2];
    assign o_act_type         = out_cfg_q[3];
    assign o_layer_index      = out_cfg_q[7:4];
    assign o_bias_shift       = out_cfg_q[12:8];
    assign o_act_shift        = out_cfg_q[15:13];
    assign o_base_addr_weight = out_base_q[19:0];
    assign o_base_addr_param  = out_base_q[31:20];

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: random descriptor tables and geometry, checked
// against a register-level model of the programmed values and the launch timing.
module tb_cnn_layer_sequencer;

    localparam int unsigned N_SLOTS = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        sl_HSEL = 1'b0, sl_HREADY = 1'b1, sl_HWRITE = 1'b0;
    logic [1:0]  sl_HTRANS = 2'b00;
    logic [2:0]  sl_HBURST = 3'd0, sl_HSIZE = 3'd2;
    logic [31:0] sl_HADDR = '0, sl_HWDATA = '0;
    logic        out_sl_HREADY;
    logic [1:0]  out_sl_HRESP;
    logic [31:0] out_sl_HRDATA;
    logic        i_end_frame = 1'b0;
    logic        o_layer_start;
    logic [11:0] o_width, o_height;
    logic [24:0] o_frame_size;
    logic [11:0] o_start_up_delay, o_hsync_delay;
    logic        o_is_first_layer, o_is_last_layer, o_is_conv3x3, o_act_type;
    logic [3:0]  o_layer_index;
    logic [4:0]  o_bias_shift;
    logic [2:0]  o_act_shift;
    logic [19:0] o_base_addr_weight;
    logic [11:0] o_base_addr_param;
    logic        o_busy, o_irq;

    cnn_layer_sequencer #(.N_SLOTS(N_SLOTS)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .sl_HSEL(sl_HSEL), .sl_HREADY(sl_HREADY), .sl_HWRITE(sl_HWRITE),
        .sl_HTRANS(sl_HTRANS), .sl_HBURST(sl_HBURST), .sl_HSIZE(sl_HSIZE),
        .sl_HADDR(sl_HADDR), .sl_HWDATA(sl_HWDATA),
        .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP),
        .out_sl_HRDATA(out_sl_HRDATA),
        .i_end_frame(i_end_frame), .o_layer_start(o_layer_start),
        .o_width(o_width), .o_height(o_height), .o_frame_size(o_frame_size),
        .o_start_up_delay(o_start_up_delay), .o_hsync_delay(o_hsync_delay),
        .o_is_first_layer(o_is_first_layer), .o_is_last_layer(o_is_last_layer),
        .o_is_conv3x3(o_is_conv3x3), .o_act_type(o_act_type),
        .o_layer_index(o_layer_index), .o_bias_shift(o_bias_shift),
        .o_act_shift(o_act_shift), .o_base_addr_weight(o_base_addr_weight),
        .o_base_addr_param(o_base_addr_param), .o_busy(o_busy), .o_irq(o_irq)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_pass = 0;
    int pulse_cnt = 0;

    // Model of the programmed register contents
    logic [11:0] m_width, m_height, m_su, m_hs;
    logic [24:0] m_frame;
    logic [15:0] m_cfg [N_SLOTS];
    logic [31:0] m_base [N_SLOTS];
    logic [4:0]  m_num;
    logic        m_irq_en, m_done, m_err;

    always @(negedge HCLK) if (o_layer_start === 1'b1) pulse_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_width = 12'd128; m_height = 12'd128; m_frame = 25'd16384;
        m_su = 12'd200; m_hs = 12'd160; m_num = '0;
        m_irq_en = 1'b0; m_done = 1'b0; m_err = 1'b0;
        for (int k = 0; k < int'(N_SLOTS); k++) begin
            m_cfg[k] = '0; m_base[k] = '0;
        end
    endtask

    function automatic logic [31:0] stat_exp(input logic busy, input int slot);
        logic [3:0] s;
        s = 4'(slot);
        return {20'd0, s, 5'd0, m_err, m_done, busy};
    endfunction

    // All bus tasks start and end #1 after a rising edge
    task automatic ahb_write(input int word, input logic [31:0] d);
        sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b1; sl_HADDR = 32'(word * 4);
        @(posedge HCLK); #1;
        sl_HSEL = 1'b0; sl_HTRANS = 2'b00; sl_HWRITE = 1'b0; sl_HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input int word, output logic [31:0] d);
        sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b0; sl_HADDR = 32'(word * 4);
        @(posedge HCLK); #1;
        sl_HSEL = 1'b0; sl_HTRANS = 2'b00;
        d = out_sl_HRDATA;
    endtask

    task automatic check_read(input string tag, input int word, input logic [31:0] exp);
        logic [31:0] d;
        ahb_read(word, d);
        check_eq(tag, 64'(d), 64'(exp));
    endtask

    task automatic check_launch(input int k);
        check_eq("launch_pulse", 64'(o_layer_start), 64'd1);
        check_eq("launch_index", 64'(o_layer_index), 64'(m_cfg[k][7:4]));
        check_eq("launch_flags", 64'({o_act_type, o_is_conv3x3, o_is_last_layer,
                                      o_is_first_layer}), 64'(m_cfg[k][3:0]));
        check_eq("launch_shifts", 64'({o_act_shift, o_bias_shift}), 64'(m_cfg[k][15:8]));
        check_eq("launch_weight", 64'(o_base_addr_weight), 64'(m_base[k] & 32'hF_FFFF));
        check_eq("launch_param", 64'(o_base_addr_param), 64'(m_base[k] >> 20));
        check_eq("launch_geom", 64'({o_frame_size, o_height, o_width}),
                 64'({m_frame, m_height, m_width}));
        check_eq("launch_delay", 64'({o_hsync_delay, o_start_up_delay}), 64'({m_hs, m_su}));
    endtask

    task automatic program_random(input int n);
        logic [31:0] d;
        d = $urandom(); ahb_write(1, d); m_width = d[11:0]; m_height = d[27:16];
        d = $urandom(); ahb_write(0, d); m_frame = d[24:0];
        d = $urandom(); ahb_write(2, d); m_su = d[11:0]; m_hs = d[23:12];
        for (int k = 0; k < n; k++) begin
            d = $urandom(); ahb_write(8 + 2 * k, d); m_cfg[k] = d[15:0];
            d = $urandom(); ahb_write(9 + 2 * k, d); m_base[k] = d;
        end
    endtask

    task automatic run_job(input int n, input logic irq);
        int base_cnt;
        program_random(n);
        ahb_write(5, {31'd0, irq}); m_irq_en = irq;
        check_read("cfg0_readback", 8, {16'd0, m_cfg[0]});
        check_read("geom_readback", 1, {4'd0, m_height, 4'd0, m_width});
        base_cnt = pulse_cnt;
        ahb_write(3, 32'((n << 4) | 1)); m_num = 5'(n);
        for (int k = 0; k < n; k++) begin
            check_launch(k);
            repeat ($urandom_range(1, 4)) @(posedge HCLK);
            #1;
            check_eq("run_no_start", 64'(o_layer_start), 64'd0);
            check_eq("run_busy", 64'(o_busy), 64'd1);
            i_end_frame = 1'b1;
            @(posedge HCLK); #1;
            i_end_frame = 1'b0;
            if (k < n - 1) begin
                check_eq("gap_no_start", 64'(o_layer_start), 64'd0);
                @(posedge HCLK); #1;
            end else begin
                m_done = 1'b1;
                check_eq("end_busy", 64'(o_busy), 64'd0);
                check_eq("end_irq_early", 64'(o_irq), 64'd0);
                @(posedge HCLK); #1;
                check_eq("end_irq", 64'(o_irq), 64'(irq));
            end
        end
        check_eq("pulse_count", 64'(pulse_cnt - base_cnt), 64'(n));
        check_read("status_done", 4, stat_exp(1'b0, n - 1));
        ahb_write(4, 32'h2); m_done = 1'b0;
        @(posedge HCLK); #1;
        check_eq("irq_cleared", 64'(o_irq), 64'd0);
        check_read("status_clr", 4, stat_exp(1'b0, n - 1));
    endtask

    initial begin
        int base_cnt;
        model_reset();
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Reset state
        check_read("rst_frame", 0, 32'h0000_4000);
        check_read("rst_wh", 1, 32'h0080_0080);
        check_read("rst_delay", 2, 32'h000A_00C8);
        check_read("rst_ctrl", 3, 32'h0);
        check_read("rst_status", 4, 32'h0);
        check_read("rst_reserved", 6, 32'h0);
        check_read("rst_unmapped", 8 + 2 * N_SLOTS + 1, 32'h0);
        check_eq("rst_outs", 64'({o_busy, o_irq, o_layer_start, o_layer_index}), 64'd0);
        check_eq("rst_geom", 64'({o_frame_size, o_height, o_width}),
                 64'({25'd16384, 12'd128, 12'd128}));
        check_eq("rst_delays", 64'({o_hsync_delay, o_start_up_delay}), 64'({12'd160, 12'd200}));
        check_eq("bus_const", 64'({out_sl_HREADY, out_sl_HRESP}), 64'({1'b1, 2'b00}));

        // Randomized jobs: three-layer run, single-layer irq run, then random
        run_job(3, 1'($urandom_range(0, 1)));
        run_job(1, 1'b1);
        for (int j = 0; j < 3; j++) run_job($urandom_range(1, N_SLOTS), 1'($urandom_range(0, 1)));

        // Illegal layer counts
        base_cnt = pulse_cnt;
        ahb_write(3, 32'h01); m_num = 5'd0; m_err = 1'b1;
        check_eq("zero_no_start", 64'({o_layer_start, o_busy}), 64'd0);
        check_read("zero_status", 4, stat_exp(1'b0, 0));
        ahb_write(4, 32'h4); m_err = 1'b0;
        check_read("err_clr", 4, stat_exp(1'b0, 0));
        ahb_write(3, 32'(((N_SLOTS + 1) << 4) | 1)); m_num = 5'(N_SLOTS + 1); m_err = 1'b1;
        check_eq("over_no_start", 64'({o_layer_start, o_busy}), 64'd0);
        check_read("over_ctrl", 3, {23'd0, m_num, 4'd0});
        check_read("over_status", 4, stat_exp(1'b0, 0));
        check_eq("illegal_pulses", 64'(pulse_cnt - base_cnt), 64'd0);
        ahb_write(4, 32'h4); m_err = 1'b0;

        // Writes while busy, then abort coinciding with end of frame
        program_random(2);
        ahb_write(3, 32'h21); m_num = 5'd2;
        check_launch(0);
        @(posedge HCLK); #1;
        ahb_write(8, ~{16'd0, m_cfg[0]});
        ahb_write(1, ~{4'd0, m_height, 4'd0, m_width});
        ahb_write(3, 32'h31);
        m_err = 1'b1;
        check_read("busy_cfg", 8, {16'd0, m_cfg[0]});
        check_read("busy_wh", 1, {4'd0, m_height, 4'd0, m_width});
        check_read("busy_status", 4, stat_exp(1'b1, 0));
        base_cnt = pulse_cnt;
        sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b1; sl_HADDR = 32'(3 * 4);
        @(posedge HCLK); #1;
        sl_HSEL = 1'b0; sl_HTRANS = 2'b00; sl_HWRITE = 1'b0; sl_HWDATA = 32'h2;
        i_end_frame = 1'b1;
        @(posedge HCLK); #1;
        i_end_frame = 1'b0;
        check_eq("abort_busy", 64'(o_busy), 64'd0);
        repeat (4) @(posedge HCLK);
        #1 i_end_frame = 1'b1;
        @(posedge HCLK); #1 i_end_frame = 1'b0;
        repeat (4) @(posedge HCLK);
        #1;
        check_eq("abort_pulses", 64'(pulse_cnt - base_cnt), 64'd0);
        check_read("abort_status", 4, stat_exp(1'b0, 0));
        check_read("abort_ctrl", 3, {23'd0, m_num, 4'd0});
        ahb_write(4, 32'h6); m_err = 1'b0;

        // Reset in the middle of a four-layer job
        program_random(4);
        ahb_write(3, 32'h41);
        check_launch(0);
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b0;
        base_cnt = pulse_cnt;
        model_reset();
        #2;
        check_eq("mid_rst_outs", 64'({o_busy, o_irq, o_layer_start, o_layer_index,
                                      o_base_addr_weight}), 64'd0);
        check_eq("mid_rst_geom", 64'({o_frame_size, o_height, o_width}),
                 64'({25'd16384, 12'd128, 12'd128}));
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(posedge HCLK);
            #1 i_end_frame = 1'b1;
            @(posedge HCLK); #1 i_end_frame = 1'b0;
        end
        repeat (5) @(posedge HCLK);
        #1;
        check_eq("post_rst_pulses", 64'(pulse_cnt - base_cnt), 64'd0);
        check_read("post_rst_wh", 1, 32'h0080_0080);
        check_read("post_rst_ctrl", 3, 32'h0);
        check_read("post_rst_cfg", 8, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
